pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: ADDR_W, default `ADDR_WIDTH (32), PC and vector width.
REQ-002 clk_i  in  1  single clock; all state on posedge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 stallreq_id_i / stallreq_ex_i / stallreq_mem_i  in  1 each  stage stall requests.
REQ-005 jump_req_i  in  1  EX-resolved taken branch/jump; jump_addr_i  in  ADDR_W  its target.
REQ-006 irq_i  in  1  level external interrupt; irq_en_i  in  1  global enable.
REQ-007 ex_valid_i  in  1  EX holds a real instruction; ex_pc_i  in  ADDR_W  its PC.
REQ-008 mret_i  in  1  MRET retiring in EX; mtvec_i  in  ADDR_W  trap vector.
REQ-009 stall_o  out  6  [0]=pc .. [5]=wb, bit=`STOP holds that stage.
REQ-010 flush_jump_o, flush_interrupt_o  out  1 each; new_pc_o  out  ADDR_W.
REQ-011 mepc_o  out  ADDR_W  saved return PC; in_isr_o  out  1; irq_ack_o  out  1.

Function
REQ-012 stall_o: mem req -> 6'b011111; else ex req -> 6'b001111; else id req -> 6'b000111; else 0; combinational, highest stage wins.
REQ-013 FSM states IDLE, DRAIN, TRAP, ISR; encoding in shared package.
REQ-014 IDLE: irq_s (see REQ-024) & irq_en_i -> DRAIN; else stay.
REQ-015 DRAIN: wait until stallreq_mem_i=0 and (ex_valid_i=1 or jump_req_i=1), then -> TRAP; mepc captured on that edge.
REQ-016 mepc capture: jump_req_i=1 -> jump_addr_i; else ex_pc_i; mepc never written outside DRAIN->TRAP or reset.
REQ-017 TRAP (exactly 1 cycle): flush_interrupt_o=1, new_pc_o=mtvec_i, irq_ack_o=1, stall_o=0, flush_jump_o=0; -> ISR.
REQ-018 ISR: in_isr_o=1, irq_s ignored (no nesting); mret_i & no mem/ex stall -> flush_jump_o=1, new_pc_o=mepc_o that cycle, -> IDLE next edge.
REQ-019 Jump (IDLE, DRAIN, ISR, no mret): flush_jump_o=jump_req_i & ~stallreq_ex_i & ~stallreq_mem_i, new_pc_o=jump_addr_i; jump under stall is withheld until stall clears.
REQ-020 Priority same cycle: TRAP flush > mret return > jump; jump coinciding with DRAIN->TRAP edge is suppressed and folded into mepc per REQ-016.
REQ-021 flush_jump_o and flush_interrupt_o never both 1; new_pc_o=0 when neither flush asserted.
REQ-022 irq_i deasserting during DRAIN: trap still taken (request latched on IDLE->DRAIN).

Reset
REQ-023 rst_i=1 asynchronously: state=IDLE, mepc_o=0, synchronizer flops=0; hence stall_o=0, flushes=0, new_pc_o=0, in_isr_o=0, irq_ack_o=0; reset mid-DRAIN/ISR abandons trap, no flush emitted.

Configuration
REQ-024 Macro PIPE_CTRL_IRQ_SYNC_EN defined: irq_s = irq_i through 2-flop synchronizer (2-cycle added latency to IDLE->DRAIN); undefined: irq_s = irq_i directly (source must be clk_i-synchronous), IDLE->DRAIN on first edge with irq_i=1.

Structure
REQ-025 defines.v holds ADDR_WIDTH, STOP, the four stall_o encodings, FSM state encodings.
REQ-026 One sub-module sync_2ff (1-bit, async reset to 0), instantiated only under PIPE_CTRL_IRQ_SYNC_EN; remainder in pipe_ctrl.

Verification
REQ-027 stallreq_ex_i=1, stallreq_id_i=1 -> stall_o=6'b001111; then mem also 1 -> 6'b011111.
REQ-028 IDLE, jump_req_i=1, jump_addr_i=32'h0000_0100, no stall -> flush_jump_o=1, new_pc_o=32'h100 same cycle; with stallreq_ex_i=1 -> flush_jump_o=0 until stall drops.
REQ-029 irq_i=1, irq_en_i=1, ex_pc_i=32'h40, ex_valid_i=1, mtvec_i=32'h200 -> one TRAP cycle: flush_interrupt_o=1, new_pc_o=32'h200, then mepc_o=32'h40, in_isr_o=1 (macro on: TRAP 2 cycles later than macro off).
REQ-030 DRAIN with stallreq_mem_i=1 for 3 cycles -> no TRAP until cycle after it clears; same-edge jump_req_i to 32'h80 -> mepc_o=32'h80, flush_jump_o=0.
REQ-031 In ISR, irq_i held high, mret_i=1 -> flush_jump_o=1, new_pc_o=mepc_o, state IDLE; rst_i pulsed mid-ISR -> all outputs 0 immediately, mepc_o=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared widths, stall encodings and FSM state encodings for pipe_ctrl
//
// Purpose: single home for the controller's text macros and its state type.
//   ADDR_WIDTH        default PC / vector width
//   STOP / NOSTOP     per-stage hold bit values in stall_o
//   STALL_*           the four stall_o patterns (bit 0 = pc .. bit 5 = wb)
//   ST_*              FSM state encodings
// Ports: none (package).
`ifndef PIPE_CTRL_DEFINES
`define PIPE_CTRL_DEFINES
`define ADDR_WIDTH 32
`define STOP       1'b1
`define NOSTOP     1'b0
`define STALL_NONE 6'b000000
`define STALL_ID   6'b000111
`define STALL_EX   6'b001111
`define STALL_MEM  6'b011111
`define ST_IDLE    2'b00
`define ST_DRAIN   2'b01
`define ST_TRAP    2'b10
`define ST_ISR     2'b11
`endif

package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = `ST_IDLE,
    DRAIN = `ST_DRAIN,
    TRAP  = `ST_TRAP,
    ISR   = `ST_ISR
  } state_t;

  // Highest stalled stage wins; every stage upstream of it is held as well.
  function automatic logic [5:0] stall_code(input logic id, input logic ex, input logic mem);
    if (mem)     return `STALL_MEM;
    else if (ex) return `STALL_EX;
    else if (id) return `STALL_ID;
    else         return `STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sync_2ff.sv
// rtl/pipe_ctrl_sync_2ff.sv - 1-bit two-flop synchronizer with async reset to 0
//
// Ports:
//   clk  in  destination clock
//   rst  in  asynchronous active-high reset, clears both flops
//   d    in  asynchronous input
//   q    out synchronized output, two clk edges behind d
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with single-level interrupt entry and MRET return
//
// Configuration macro: PIPE_CTRL_IRQ_SYNC_EN
//   defined   : irq_i passes through sync_2ff (two extra cycles before IDLE->DRAIN)
//   undefined : irq_i used directly and must be clk_i-synchronous
//
// Ports:
//   clk_i, rst_i                        clock, asynchronous active-high reset
//   stallreq_id_i/ex_i/mem_i            stage stall requests
//   jump_req_i, jump_addr_i             EX-resolved taken branch and its target
//   irq_i, irq_en_i                     level interrupt and global enable
//   ex_valid_i, ex_pc_i                 EX holds a real instruction, and its PC
//   mret_i, mtvec_i                     MRET in EX, trap vector
//   stall_o                             per-stage hold, [0]=pc .. [5]=wb
//   flush_jump_o, flush_interrupt_o     redirect strobes (mutually exclusive)
//   new_pc_o                            redirect target, 0 when no flush
//   mepc_o, in_isr_o, irq_ack_o         saved return PC, handler active, trap acknowledge
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
  parameter int ADDR_W = `ADDR_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stallreq_id_i,
  input  logic              stallreq_ex_i,
  input  logic              stallreq_mem_i,
  input  logic              jump_req_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              irq_i,
  input  logic              irq_en_i,
  input  logic              ex_valid_i,
  input  logic [ADDR_W-1:0] ex_pc_i,
  input  logic              mret_i,
  input  logic [ADDR_W-1:0] mtvec_i,
  output logic [5:0]        stall_o,
  output logic              flush_jump_o,
  output logic              flush_interrupt_o,
  output logic [ADDR_W-1:0] new_pc_o,
  output logic [ADDR_W-1:0] mepc_o,
  output logic              in_isr_o,
  output logic              irq_ack_o
);

  state_t            state, state_nxt;
  logic              irq_s;
  logic              mepc_we;
  logic [ADDR_W-1:0] mepc_nxt;
  logic              jump_ok;

`ifdef PIPE_CTRL_IRQ_SYNC_EN
  sync_2ff u_irq_sync (
    .clk (clk_i),
    .rst (rst_i),
    .d   (irq_i),
    .q   (irq_s)
  );
`else
  assign irq_s = irq_i;
`endif

  // A jump is only released once the stages that would execute the redirect
  // (EX and MEM) are moving; an ID stall does not block it.
  assign jump_ok = jump_req_i & ~stallreq_ex_i & ~stallreq_mem_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      mepc_o <= '0;
    end else begin
      state <= state_nxt;
      if (mepc_we) mepc_o <= mepc_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    stall_o           = stall_code(stallreq_id_i, stallreq_ex_i, stallreq_mem_i);
    flush_jump_o      = 1'b0;
    flush_interrupt_o = 1'b0;
    new_pc_o          = '0;
    in_isr_o          = 1'b0;
    irq_ack_o         = 1'b0;
    mepc_we           = 1'b0;
    // A jump resolving on the trap edge is the next instruction to run, so it
    // becomes the return address instead of being flushed.
    mepc_nxt          = jump_req_i ? jump_addr_i : ex_pc_i;

    case (state)
      IDLE: begin
        if (irq_s && irq_en_i) state_nxt = DRAIN;
        if (jump_ok) begin
          flush_jump_o = 1'b1;
          new_pc_o     = jump_addr_i;
        end
      end
      DRAIN: begin
        // Trap only once MEM is free and there is a precise PC to return to.
        if (!stallreq_mem_i && (ex_valid_i || jump_req_i)) begin
          state_nxt = TRAP;
          mepc_we   = 1'b1;
        end else if (jump_ok) begin
          flush_jump_o = 1'b1;
          new_pc_o     = jump_addr_i;
        end
      end
      TRAP: begin
        stall_o           = `STALL_NONE;
        flush_interrupt_o = 1'b1;
        new_pc_o          = mtvec_i;
        irq_ack_o         = 1'b1;
        state_nxt         = ISR;
      end
      ISR: begin
        in_isr_o = 1'b1;
        // irq_s is deliberately not looked at here: no nesting.
        if (mret_i) begin
          if (!stallreq_mem_i && !stallreq_ex_i) begin
            flush_jump_o = 1'b1;
            new_pc_o     = mepc_o;
            state_nxt    = IDLE;
          end
        end else if (jump_ok) begin
          flush_jump_o = 1'b1;
          new_pc_o     = jump_addr_i;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl (vector table plus scoreboarded sequences)
module tb_pipe_ctrl;

  typedef struct packed {
    logic        rst;
    logic        sid;
    logic        sex;
    logic        smem;
    logic        jreq;
    logic [31:0] jaddr;
    logic        irq;
    logic        irq_en;
    logic        exv;
    logic [31:0] expc;
    logic        mret;
    logic [31:0] mtvec;
  } in_t;

  typedef struct packed {
    logic [5:0]  stall;
    logic        fj;
    logic        fi;
    logic [31:0] npc;
    logic [31:0] mepc;
    logic        isr;
    logic        ack;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        stallreq_id_i = 1'b0, stallreq_ex_i = 1'b0, stallreq_mem_i = 1'b0;
  logic        jump_req_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        irq_i = 1'b0, irq_en_i = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic [31:0] ex_pc_i = '0;
  logic        mret_i = 1'b0;
  logic [31:0] mtvec_i = '0;
  logic [5:0]  stall_o;
  logic        flush_jump_o, flush_interrupt_o;
  logic [31:0] new_pc_o, mepc_o;
  logic        in_isr_o, irq_ack_o;

  int n_vec = 0;
  int n_bad = 0;
  out_t exp_q[$];

  in_t  cur;
  out_t ex;
  vec_t tbl[12];

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .stallreq_id_i     (stallreq_id_i),
    .stallreq_ex_i     (stallreq_ex_i),
    .stallreq_mem_i    (stallreq_mem_i),
    .jump_req_i        (jump_req_i),
    .jump_addr_i       (jump_addr_i),
    .irq_i             (irq_i),
    .irq_en_i          (irq_en_i),
    .ex_valid_i        (ex_valid_i),
    .ex_pc_i           (ex_pc_i),
    .mret_i            (mret_i),
    .mtvec_i           (mtvec_i),
    .stall_o           (stall_o),
    .flush_jump_o      (flush_jump_o),
    .flush_interrupt_o (flush_interrupt_o),
    .new_pc_o          (new_pc_o),
    .mepc_o            (mepc_o),
    .in_isr_o          (in_isr_o),
    .irq_ack_o         (irq_ack_o)
  );

  // Scoreboard consumer: one expectation per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t e, a;
      e = exp_q.pop_front();
      a = '{stall: stall_o, fj: flush_jump_o, fi: flush_interrupt_o, npc: new_pc_o,
            mepc: mepc_o, isr: in_isr_o, ack: irq_ack_o};
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL vec%0d @%0t: got stall=%b fj=%b fi=%b npc=%h mepc=%h isr=%b ack=%b, want stall=%b fj=%b fi=%b npc=%h mepc=%h isr=%b ack=%b",
                 n_vec, $time, a.stall, a.fj, a.fi, a.npc, a.mepc, a.isr, a.ack,
                 e.stall, e.fj, e.fi, e.npc, e.mepc, e.isr, e.ack);
      end
    end
  end

  task automatic apply(input in_t i);
    rst_i          = i.rst;
    stallreq_id_i  = i.sid;
    stallreq_ex_i  = i.sex;
    stallreq_mem_i = i.smem;
    jump_req_i     = i.jreq;
    jump_addr_i    = i.jaddr;
    irq_i          = i.irq;
    irq_en_i       = i.irq_en;
    ex_valid_i     = i.exv;
    ex_pc_i        = i.expc;
    mret_i         = i.mret;
    mtvec_i        = i.mtvec;
  endtask

  task automatic step(input in_t i, input out_t e);
    @(posedge clk);
    #1;
    apply(i);
    exp_q.push_back(e);
  endtask

  function automatic out_t quiet(input logic [31:0] mepc);
    out_t o;
    o = '0;
    o.mepc = mepc;
    return o;
  endfunction

  function automatic vec_t tv(input logic sid, input logic sex, input logic smem,
                              input logic jreq, input logic [31:0] jaddr,
                              input logic irq, input logic en,
                              input logic [5:0] xs, input logic xfj, input logic [31:0] xpc);
    vec_t v;
    v = '0;
    v.i.sid = sid; v.i.sex = sex; v.i.smem = smem;
    v.i.jreq = jreq; v.i.jaddr = jaddr;
    v.i.irq = irq; v.i.irq_en = en;
    v.e.stall = xs; v.e.fj = xfj; v.e.npc = xpc;
    return v;
  endfunction

  task automatic do_reset();
    cur = '0;
    cur.rst = 1'b1;
    step(cur, quiet(32'h0));
    cur.rst = 1'b0;
    step(cur, quiet(32'h0));
  endtask

  // Raise irq in IDLE; the DUT sits in IDLE for the synchronizer latency.
  task automatic irq_entry(input logic [31:0] mepc);
    cur.irq = 1'b1;
    cur.irq_en = 1'b1;
    step(cur, quiet(mepc));
`ifdef PIPE_CTRL_IRQ_SYNC_EN
    step(cur, quiet(mepc));
    step(cur, quiet(mepc));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want finish before it");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = tv(0, 0, 0, 0, 32'h0,     0, 0, 6'b000000, 0, 32'h0);
    tbl[1]  = tv(1, 0, 0, 0, 32'h0,     0, 0, 6'b000111, 0, 32'h0);
    tbl[2]  = tv(1, 1, 0, 0, 32'h0,     0, 0, 6'b001111, 0, 32'h0);
    tbl[3]  = tv(1, 1, 1, 0, 32'h0,     0, 0, 6'b011111, 0, 32'h0);
    tbl[4]  = tv(0, 0, 1, 0, 32'h0,     0, 0, 6'b011111, 0, 32'h0);
    tbl[5]  = tv(0, 0, 0, 1, 32'h100,   0, 0, 6'b000000, 1, 32'h100);
    tbl[6]  = tv(0, 1, 0, 1, 32'h100,   0, 0, 6'b001111, 0, 32'h0);
    tbl[7]  = tv(0, 0, 1, 1, 32'h100,   0, 0, 6'b011111, 0, 32'h0);
    tbl[8]  = tv(1, 0, 0, 1, 32'h100,   0, 0, 6'b000111, 1, 32'h100);
    tbl[9]  = tv(0, 0, 0, 1, 32'h100,   0, 0, 6'b000000, 1, 32'h100);
    tbl[10] = tv(0, 0, 0, 1, 32'h1fc,   1, 0, 6'b000000, 1, 32'h1fc);
    tbl[11] = tv(0, 0, 0, 0, 32'h0,     1, 0, 6'b000000, 0, 32'h0);

    // Reset state, sampled while rst_i is still high.
    cur = '0;
    cur.rst = 1'b1;
    step(cur, quiet(32'h0));
    cur.rst = 1'b0;

    for (int k = 0; k < 12; k++) step(tbl[k].i, tbl[k].e);

    // Trap entry, ISR jump, stalled and clean MRET with irq still high.
    do_reset();
    cur.mtvec = 32'h200;
    irq_entry(32'h0);
    cur.exv = 1'b1; cur.expc = 32'h40;
    step(cur, quiet(32'h0));                                   // DRAIN, trap edge
    cur.exv = 1'b0; cur.sex = 1'b1;
    ex = quiet(32'h40); ex.fi = 1'b1; ex.npc = 32'h200; ex.ack = 1'b1;
    step(cur, ex);                                             // TRAP ignores stall
    cur.sex = 1'b0;
    ex = quiet(32'h40); ex.isr = 1'b1;
    step(cur, ex);                                             // ISR
    cur.jreq = 1'b1; cur.jaddr = 32'h300;
    ex.fj = 1'b1; ex.npc = 32'h300;
    step(cur, ex);                                             // jump inside ISR
    cur.jreq = 1'b0; cur.mret = 1'b1; cur.sex = 1'b1;
    ex = quiet(32'h40); ex.isr = 1'b1; ex.stall = 6'b001111;
    step(cur, ex);                                             // MRET held by EX stall
    cur.sex = 1'b0;
    ex = quiet(32'h40); ex.isr = 1'b1; ex.fj = 1'b1; ex.npc = 32'h40;
    step(cur, ex);                                             // MRET return
    cur.mret = 1'b0;
    step(cur, quiet(32'h40));                                  // back in IDLE

    // DRAIN held by MEM stall, irq dropped, jump folded into mepc, reset mid-ISR.
    do_reset();
    cur.mtvec = 32'h200;
    irq_entry(32'h0);
    cur.irq = 1'b0; cur.smem = 1'b1; cur.exv = 1'b1; cur.expc = 32'h44;
    ex = quiet(32'h0); ex.stall = 6'b011111;
    for (int k = 0; k < 3; k++) step(cur, ex);
    cur.smem = 1'b0; cur.jreq = 1'b1; cur.jaddr = 32'h80;
    step(cur, quiet(32'h0));                                   // trap edge, jump suppressed
    cur.jreq = 1'b0; cur.exv = 1'b0;
    ex = quiet(32'h80); ex.fi = 1'b1; ex.npc = 32'h200; ex.ack = 1'b1;
    step(cur, ex);
    ex = quiet(32'h80); ex.isr = 1'b1;
    step(cur, ex);
    cur.rst = 1'b1;
    step(cur, quiet(32'h0));                                   // async reset seen same cycle
    cur.rst = 1'b0;
    step(cur, quiet(32'h0));

    // Reset mid-DRAIN abandons the trap.
    do_reset();
    cur.mtvec = 32'h200;
    irq_entry(32'h0);
    cur.smem = 1'b1;
    ex = quiet(32'h0); ex.stall = 6'b011111;
    step(cur, ex);
    cur.smem = 1'b0; cur.rst = 1'b1;
    step(cur, quiet(32'h0));
    cur.rst = 1'b0; cur.irq = 1'b0; cur.exv = 1'b1; cur.expc = 32'h48;
    step(cur, quiet(32'h0));
    step(cur, quiet(32'h0));

    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
